// File: rtl/sram_nco_pkg.sv
// Shared types and geometry for the NCO sine-LUT SRAM controller.
// The quarter-wave table option is selected with the NCO_QUARTER_WAVE_EN macro.
package sram_nco_pkg;
   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      DRAIN
   } nco_state_t;

   localparam int FIFO_DEPTH   = 4;
   localparam int SRAM_WORDS   = 128;
   localparam int SRAM_ADDR_W  = 7;
   localparam int SRAM_DATA_W  = 32;
   localparam int SRAM_WMASK_W = 4;
endpackage

// File: rtl/sram_nco_fifo.sv
// Small synchronous sample FIFO with occupancy count; DEPTH must be a power of two.
module sram_nco_fifo
   import sram_nco_pkg::*;
#(
   parameter int WIDTH = SRAM_DATA_W,
   parameter int DEPTH = FIFO_DEPTH,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign dout = mem[rd_ptr];
endmodule

// File: rtl/sram_nco_lut_ctrl.sv
// Loads the sine LUT through SRAM port 0, then streams phase-indexed samples read on port 1.
// Define NCO_QUARTER_WAVE_EN for a quarter-wave table with address mirroring and sign restore.
module sram_nco_lut_ctrl
   import sram_nco_pkg::*;
#(
   parameter int ADDR_WIDTH  = SRAM_ADDR_W,
   parameter int DATA_WIDTH  = SRAM_DATA_W,
   parameter int PHASE_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_start,
   input  logic                    run_en,
   input  logic                    phase_clr,
   input  logic [PHASE_WIDTH-1:0]  freq_word,
   input  logic                    ld_valid,
   output logic                    ld_ready,
   input  logic [DATA_WIDTH-1:0]   ld_data,
   output logic                    ld_done,
   output logic                    smp_valid,
   input  logic                    smp_ready,
   output logic [DATA_WIDTH-1:0]   smp_data,
   output logic                    busy,
   output logic                    sram_csb0,
   output logic                    sram_web0,
   output logic [SRAM_WMASK_W-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0]   sram_addr0,
   output logic [DATA_WIDTH-1:0]   sram_din0,
   output logic                    sram_csb1,
   output logic [ADDR_WIDTH-1:0]   sram_addr1,
   input  logic [DATA_WIDTH-1:0]   sram_dout1
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   nco_state_t             state, state_nxt;
   logic [ADDR_WIDTH-1:0]  wr_cnt;
   logic [PHASE_WIDTH-1:0] phase;
   logic                   rd_ret;
   logic [1:0]             inflight;
   logic [3:0]             occupancy;
   logic [CW-1:0]          fifo_count;
   logic                   ld_fire, issue, pop;
   logic [ADDR_WIDTH-1:0]  rd_addr;
   logic [DATA_WIDTH-1:0]  push_data;

   assign ld_ready  = (state == LOAD);
   assign ld_fire   = ld_valid && ld_ready;
   assign busy      = (state != IDLE);
   assign smp_valid = (fifo_count != '0);
   assign pop       = smp_valid && smp_ready;
   // A read is in flight from its issue edge until its word is pushed two edges later.
   assign inflight  = {1'b0, ~sram_csb1} + {1'b0, rd_ret};
   assign occupancy = 4'(fifo_count) - 4'(pop) + 4'(inflight);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if (load_start)  state_nxt = LOAD;
            else if (run_en) state_nxt = RUN;
         end
         LOAD: begin
            if (ld_fire && wr_cnt == '1) state_nxt = IDLE;
         end
         RUN: begin
            if (!run_en) state_nxt = DRAIN;
            else         issue = (occupancy < 4'(FIFO_DEPTH));
         end
         DRAIN: begin
            if (inflight == 2'd0) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sram_csb0   <= 1'b1;
         sram_web0   <= 1'b1;
         sram_wmask0 <= '0;
         sram_addr0  <= '0;
         sram_din0   <= '0;
         wr_cnt      <= '0;
         ld_done     <= 1'b0;
      end else begin
         sram_csb0   <= ~ld_fire;
         sram_web0   <= ~ld_fire;
         sram_wmask0 <= ld_fire ? '1 : '0;
         ld_done     <= ld_fire && (wr_cnt == '1);
         if (ld_fire) begin
            sram_addr0 <= wr_cnt;
            sram_din0  <= ld_data;
            wr_cnt     <= wr_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sram_csb1  <= 1'b1;
         sram_addr1 <= '0;
         phase      <= '0;
         rd_ret     <= 1'b0;
      end else begin
         sram_csb1 <= ~issue;
         rd_ret    <= ~sram_csb1;
         if (issue) begin
            sram_addr1 <= rd_addr;
            phase      <= phase + freq_word;
         end else if (state == IDLE && phase_clr) begin
            phase <= '0;
         end
      end
   end

`ifdef NCO_QUARTER_WAVE_EN
   logic [ADDR_WIDTH-1:0] quad_addr;
   logic                  sign_iss, sign_ret;

   assign quad_addr = phase[PHASE_WIDTH-3 -: ADDR_WIDTH];
   assign rd_addr   = phase[PHASE_WIDTH-2] ? ~quad_addr : quad_addr;

   // The half-wave sign rides alongside the read so the returning word can be negated.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sign_iss <= 1'b0;
         sign_ret <= 1'b0;
      end else begin
         if (issue) sign_iss <= phase[PHASE_WIDTH-1];
         sign_ret <= sign_iss;
      end
   end

   always_comb begin
      push_data = sram_dout1;
      if (sign_ret) begin
         if (sram_dout1 == {1'b1, {(DATA_WIDTH-1){1'b0}}}) push_data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
         else                                              push_data = -sram_dout1;
      end
   end
`else
   assign rd_addr   = phase[PHASE_WIDTH-1 -: ADDR_WIDTH];
   assign push_data = sram_dout1;
`endif

   sram_nco_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rd_ret),
      .din   (push_data),
      .pop   (pop),
      .dout  (smp_data),
      .count (fifo_count)
   );
endmodule
